key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 182 ++++++++++++++++++
 tb/tb_key_conditioner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton front end: sync, debounce, strobes, auto-repeat,
// press toggle and a two-digit BCD press counter.
//   iclk, irst_n (async, active-low), ikey (raw, active-low),
//   iclr (sync clear of count/toggle)
//   okey_level/press/release/repeat/toggle per key, okey_count BCD
module key_conditioner #(
   parameter int NKEYS           = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int CNT_W           = 25
) (
   input  logic             iclk,
   input  logic             irst_n,
   input  logic [NKEYS-1:0] ikey,
   input  logic             iclr,
   output logic [NKEYS-1:0] okey_level,
   output logic [NKEYS-1:0] okey_press,
   output logic [NKEYS-1:0] okey_release,
   output logic [NKEYS-1:0] okey_repeat,
   output logic [NKEYS-1:0] otoggle,
   output logic [7:0]       okey_count
);

   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_MAX = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_e;

   logic [NKEYS-1:0] r_sync1, r_sync2;
   logic [NKEYS-1:0] w_s;
   logic [NKEYS-1:0] w_level_nxt, w_press_nxt, w_rel_nxt, w_rep_nxt;
   logic [CNT_W-1:0] r_db_cnt     [NKEYS];
   logic [CNT_W-1:0] w_db_cnt_nxt [NKEYS];
   logic [CNT_W-1:0] r_rp_cnt     [NKEYS];
   logic [CNT_W-1:0] w_rp_cnt_nxt [NKEYS];
   rpt_e             r_st         [NKEYS];
   rpt_e             w_st_nxt     [NKEYS];
   logic [7:0]       w_count_inc;

   // Reset to 1 so keys read as released until real samples arrive
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= ikey;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   // The level flips once DEBOUNCE_CYCLES mismatches were counted
   // and the current cycle still mismatches.
   always_comb begin
      w_level_nxt = okey_level;
      for (int k = 0; k < NKEYS; k++) begin
         w_db_cnt_nxt[k] = '0;
         if (w_s[k] != okey_level[k]) begin
            if (r_db_cnt[k] == DB_MAX)
               w_level_nxt[k] = w_s[k];
            else
               w_db_cnt_nxt[k] = r_db_cnt[k] + C_ONE;
         end
      end
   end

   assign w_press_nxt = w_level_nxt & ~okey_level;
   assign w_rel_nxt   = ~w_level_nxt & okey_level;

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int k = 0; k < NKEYS; k++) begin
            r_db_cnt[k] <= '0;
            r_rp_cnt[k] <= '0;
            r_st[k]     <= IDLE;
         end
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            r_db_cnt[k] <= w_db_cnt_nxt[k];
            r_rp_cnt[k] <= w_rp_cnt_nxt[k];
            r_st[k]     <= w_st_nxt[k];
         end
      end
   end

   // Repeat FSM next state; release wins in every state
   always_comb begin
      for (int k = 0; k < NKEYS; k++) begin
         w_st_nxt[k]     = r_st[k];
         w_rp_cnt_nxt[k] = r_rp_cnt[k];
         if (w_rel_nxt[k]) begin
            w_st_nxt[k]     = IDLE;
            w_rp_cnt_nxt[k] = '0;
         end else begin
            unique case (r_st[k])
               IDLE: begin
                  if (w_press_nxt[k]) begin
                     w_st_nxt[k]     = DELAY;
                     w_rp_cnt_nxt[k] = '0;
                  end
               end
               DELAY: begin
                  if (r_rp_cnt[k] == RD_MAX) begin
                     w_st_nxt[k]     = REPEAT;
                     w_rp_cnt_nxt[k] = '0;
                  end else begin
                     w_rp_cnt_nxt[k] = r_rp_cnt[k] + C_ONE;
                  end
               end
               REPEAT: begin
                  if (r_rp_cnt[k] == RR_MAX)
                     w_rp_cnt_nxt[k] = '0;
                  else
                     w_rp_cnt_nxt[k] = r_rp_cnt[k] + C_ONE;
               end
               default: begin
                  w_st_nxt[k]     = IDLE;
                  w_rp_cnt_nxt[k] = '0;
               end
            endcase
         end
      end
   end

   // Repeat FSM output
   always_comb begin
      w_rep_nxt = '0;
      for (int k = 0; k < NKEYS; k++) begin
         if (!w_rel_nxt[k]) begin
            unique case (r_st[k])
               IDLE:    w_rep_nxt[k] = w_press_nxt[k];
               DELAY:   w_rep_nxt[k] = (r_rp_cnt[k] == RD_MAX);
               REPEAT:  w_rep_nxt[k] = (r_rp_cnt[k] == RR_MAX);
               default: w_rep_nxt[k] = 1'b0;
            endcase
         end
      end
   end

   // BCD +1 with 99 -> 00 wrap
   always_comb begin
      w_count_inc = okey_count;
      if (okey_count[3:0] >= 4'd9) begin
         w_count_inc[3:0] = 4'd0;
         if (okey_count[7:4] >= 4'd9)
            w_count_inc[7:4] = 4'd0;
         else
            w_count_inc[7:4] = okey_count[7:4] + 4'd1;
      end else begin
         w_count_inc[3:0] = okey_count[3:0] + 4'd1;
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         okey_level   <= '0;
         okey_press   <= '0;
         okey_release <= '0;
         okey_repeat  <= '0;
         otoggle      <= '0;
         okey_count   <= 8'h00;
      end else begin
         okey_level   <= w_level_nxt;
         okey_press   <= w_press_nxt;
         okey_release <= w_rel_nxt;
         okey_repeat  <= w_rep_nxt;
         if (iclr) begin
            otoggle    <= '0;
            okey_count <= 8'h00;
         end else begin
            otoggle <= otoggle ^ w_press_nxt;
            if (|w_press_nxt)
               okey_count <= w_count_inc;
         end
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key
// activity, compared every cycle against a behavioural model.
module tb_key_conditioner;

   localparam int NK = 5;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;
   localparam int LAT = 1 + 2 + DB;

   logic          iclk   = 1'b0;
   logic          irst_n = 1'b0;
   logic [NK-1:0] ikey   = '1;
   logic          iclr   = 1'b0;
   logic [NK-1:0] okey_level, okey_press, okey_release;
   logic [NK-1:0] okey_repeat, otoggle;
   logic [7:0]    okey_count;

   key_conditioner #(
      .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR), .CNT_W(8)
   ) dut (
      .iclk(iclk), .irst_n(irst_n), .ikey(ikey), .iclr(iclr),
      .okey_level(okey_level), .okey_press(okey_press),
      .okey_release(okey_release), .okey_repeat(okey_repeat),
      .otoggle(otoggle), .okey_count(okey_count)
   );

   always #5 iclk = ~iclk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [NK-1:0] m_level, m_press, m_rel, m_rep, m_tog;
   int            m_n, m_t;
   int            m_pt [NK];
   logic [NK-1:0] m_raw [$];
   logic [NK-1:0] m_win [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int n);
      logic [3:0] t, u;
      t = 4'(n / 10);
      u = 4'(n % 10);
      return {t, u};
   endfunction

   task automatic model_reset();
      m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
      m_tog = '0; m_n = 0; m_t = 0;
      for (int k = 0; k < NK; k++) m_pt[k] = 0;
      m_raw.delete();
      m_raw.push_back('1);
      m_raw.push_back('1);
      m_win.delete();
   endtask

   // A level flips when the last DB+1 synchronized samples all
   // disagree with it; repeats follow from time since the press.
   task automatic model_step();
      logic [NK-1:0] s, nl;
      int d;
      bit all;
      m_t++;
      s = ~m_raw.pop_front();
      m_raw.push_back(ikey);
      m_win.push_back(s);
      if (m_win.size() > DB + 1) void'(m_win.pop_front());
      nl = m_level;
      if (m_win.size() == DB + 1) begin
         for (int k = 0; k < NK; k++) begin
            all = 1'b1;
            foreach (m_win[j])
               if (m_win[j][k] == m_level[k]) all = 1'b0;
            if (all) nl[k] = ~m_level[k];
         end
      end
      m_press = nl & ~m_level;
      m_rel   = ~nl & m_level;
      m_rep   = '0;
      for (int k = 0; k < NK; k++) begin
         if (m_press[k]) m_pt[k] = m_t;
         if (nl[k]) begin
            d = m_t - m_pt[k];
            if (d == 0 || (d >= RD && (d - RD) % RR == 0))
               m_rep[k] = 1'b1;
         end
      end
      if (iclr) begin
         m_n = 0;
         m_tog = '0;
      end else begin
         if (m_press != '0) m_n = (m_n + 1) % 100;
         m_tog ^= m_press;
      end
      m_level = nl;
   endtask

   task automatic check_all();
      chk("level",   32'(okey_level),   32'(m_level));
      chk("press",   32'(okey_press),   32'(m_press));
      chk("release", 32'(okey_release), 32'(m_rel));
      chk("repeat",  32'(okey_repeat),  32'(m_rep));
      chk("toggle",  32'(otoggle),      32'(m_tog));
      chk("count",   32'(okey_count),   32'(bcd(m_n)));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_level"}, 32'(okey_level), 0);
      chk({tag, "_press"}, 32'(okey_press), 0);
      chk({tag, "_rel"},   32'(okey_release), 0);
      chk({tag, "_rep"},   32'(okey_repeat), 0);
      chk({tag, "_tog"},   32'(otoggle), 0);
      chk({tag, "_cnt"},   32'(okey_count), 0);
   endtask

   task automatic cycle();
      @(posedge iclk);
      model_step();
      #1;
      check_all();
      @(negedge iclk);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_press(input int k, output int idx);
      idx = -1;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (okey_press[k]) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic wait_rel(input int k, output int idx);
      idx = -1;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (okey_release[k]) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic tap(input int k);
      ikey[k] = 1'b0;
      cycles(DB + 3);
      ikey[k] = 1'b1;
      cycles(DB + 3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      logic [31:0] rm, exp_rm;

      model_reset();
      repeat (3) @(posedge iclk);
      #1;
      check_zero("reset");
      @(negedge iclk);
      ikey[1] = 1'b0;
      irst_n  = 1'b1;
      wait_press(1, idx);
      chk("held_from_reset_edge", 32'(idx), 32'(LAT));
      ikey[1] = 1'b1;
      cycles(DB + 4);

      ikey[0] = 1'b0;
      cycles(3);
      ikey[0] = 1'b1;
      cycles(DB + 4);
      chk("glitch_count", 32'(okey_count), 32'h01);

      ikey[0] = 1'b0;
      wait_press(0, idx);
      chk("debounce_edge", 32'(idx), 32'(LAT));
      cycle();
      chk("press_width", 32'(okey_press[0]), 0);
      chk("debounce_count", 32'(okey_count), 32'h02);
      ikey[0] = 1'b1;
      cycles(DB + 4);

      ikey[2] = 1'b0;
      wait_press(2, idx);
      rm = '0;
      rm[0] = okey_repeat[2];
      for (int o = 1; o <= 30; o++) begin
         cycle();
         rm[o] = okey_repeat[2];
      end
      exp_rm = '0;
      exp_rm[0] = 1'b1;
      for (int o = RD; o <= 30; o += RR) exp_rm[o] = 1'b1;
      chk("repeat_pattern", rm, exp_rm);
      ikey[2] = 1'b1;
      wait_rel(2, idx);
      chk("release_edge", 32'(idx), 32'(LAT));
      cycles(12);

      iclr = 1'b1;
      cycle();
      iclr = 1'b0;
      for (int i = 0; i < 99; i++) tap(1);
      chk("bcd_99", 32'(okey_count), 32'h99);
      tap(1);
      chk("bcd_wrap", 32'(okey_count), 32'h00);
      chk("toggle_even", 32'(otoggle[1]), 0);

      ikey[4:3] = 2'b00;
      cycles(DB + 3);
      chk("simul_press", 32'(okey_press), 32'b11000);
      chk("simul_count", 32'(okey_count), 32'h01);
      ikey[4:3] = 2'b11;
      cycles(DB + 4);
      ikey[4:3] = 2'b00;
      cycles(DB + 2);
      iclr = 1'b1;
      cycle();
      iclr = 1'b0;
      chk("clr_press", 32'(okey_press), 32'b11000);
      chk("clr_count", 32'(okey_count), 32'h00);
      chk("clr_toggle", 32'(otoggle), 0);
      ikey[4:3] = 2'b11;
      cycles(DB + 4);

      ikey[2] = 1'b0;
      cycles(DB + 3 + RD + 4);
      #2;
      irst_n = 1'b0;
      #1;
      check_zero("async");
      model_reset();
      @(negedge iclk);
      @(negedge iclk);
      irst_n = 1'b1;
      wait_press(2, idx);
      chk("reaccept_edge", 32'(idx), 32'(LAT));
      ikey[2] = 1'b1;
      cycles(DB + 4);

      for (int i = 0; i < 300; i++) begin
         ikey = NK'($urandom);
         iclr = ($urandom_range(0, 15) == 0);
         cycle();
         iclr = 1'b0;
         cycles($urandom_range(0, 9));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
